multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, one register file, used across several cycles per instruction.
- Decodes opcode/funct from the instruction register and drives all mux selects, write enables and ALU op codes cycle by cycle.
- Waits on a memory ready handshake and counts retired instructions.
- Sits between the IR/zero flag and the datapath. Replaces the single-cycle decoder in the multicycle core.

Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE to end of instruction
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  0: memory address = PC; 1: address = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  load IR
- pc_en  out  1  PC load enable (pc_write OR (branch AND zero))
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR)
- reg_dest  out  1  1: rd; 0: rt
- mem2reg  out  1  1: register WD = memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0: PC; 1: A register
- alu_src_b  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- alu_op  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- illegal_op  out  1  one-cycle pulse on unsupported instruction
- state  out  4  current state code (debug)
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n=0): state=FETCH (0), retired=0.
- All outputs are combinational from state, plus mem_ready/zero where noted. Outputs not listed for a state are 0.
- While in reset, outputs are the FETCH values with ir_write=pc_en=0.
- Reset asserted mid-instruction aborts it: no counter increment, no pending write.
- States, with outputs -> next state:
  - FETCH(0): iord=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_src=00. ir_write=pc_en=mem_ready. mem_ready -> DECODE; else hold (stall any number of cycles).
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=010 (precompute branch target). Next by opcode: 0x23/0x2B -> MEMADR; 0x00 -> EXECUTE; 0x04 -> BRANCH; 0x08/0x09 -> ADDIEX; 0x02 -> JUMP; other -> ILLEGAL.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=010. opcode 0x23 -> MEMRD; 0x2B -> MEMWR.
  - MEMRD(3): iord=1. mem_ready -> MEMWB; else hold.
  - MEMWB(4): reg_dest=0, mem2reg=1, reg_write=1 -> FETCH.
  - MEMWR(5): iord=1, mem_write=1, held until mem_ready. mem_ready -> FETCH.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00. alu_op from funct: 0x20/0x21=010, 0x22/0x23=110, 0x24=000, 0x25=001, 0x2A/0x2B=111 -> ALUWB. Any other funct -> ILLEGAL, alu_op=010, no write.
  - ALUWB(7): reg_dest=1, reg_write=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_en=zero -> FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=010 -> ADDIWB.
  - ADDIWB(10): reg_dest=0, reg_write=1 -> FETCH.
  - JUMP(11): pc_src=10, pc_en=1 -> FETCH.
  - ILLEGAL(12): illegal_op=1 -> FETCH. No register, memory or PC write.
  - Codes 13-15: unreachable. If entered, next state is FETCH.
- retired increments by 1 on each exit to FETCH from MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB, JUMP or JR. It does not increment on exit from ILLEGAL.
- retired wraps modulo 2^CNT_W.
- Latencies (zero-wait memory): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Optional Feature:
- Macro: MULTICYCLE_CTRL_JR_EN
- Defined: funct 0x08 in EXECUTE -> JR(13). JR drives pc_src=11, pc_en=1, then -> FETCH and counts as retired.
- Undefined: funct 0x08 -> ILLEGAL. State 13 is unused.

Test Plan:
- Reset with rst_n=0 mid-MEMRD, release -> state=0, retired=0, next FETCH with mem_ready=1 gives ir_write=pc_en=1.
- lw (opcode 0x23), mem_ready held 0 for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. reg_write=mem2reg=1 only in MEMWB. retired +1.
- add (opcode 0x00, funct 0x20), then slt (funct 0x2A) -> alu_op 010 then 111 in EXECUTE. reg_dest=1, reg_write=1 in ALUWB. Each instruction 4 cycles.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 for the first, pc_en=0 for the second. retired +2.
- opcode 0x3F, then R-type funct 0x00 -> illegal_op pulses once each, no reg_write/mem_write, retired unchanged.
- funct 0x08: with MULTICYCLE_CTRL_JR_EN -> state 13, pc_src=11, pc_en=1; without the macro -> illegal_op=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle controller and its datapath
//
// Signal summary (direction as seen from the controller, modport master):
//   in  opcode[5:0], funct[5:0]  instruction register fields, stable from DECODE onward
//   in  zero                     ALU zero flag
//   in  mem_ready                memory completes the current access this cycle
//   out iord, mem_write, ir_write, pc_en, pc_src[1:0], reg_dest, mem2reg,
//       reg_write, alu_src_a, alu_src_b[1:0], alu_op[2:0]   datapath controls
//   out illegal_op               one-cycle pulse on an unsupported instruction
//   out state[3:0]               current state code (debug)
//   out retired[CNT_W-1:0]       retired-instruction count
// Modport slave is the datapath side of the same bundle.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             reg_dest;
    logic             mem2reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output iord, mem_write, ir_write, pc_en, pc_src, reg_dest, mem2reg,
               reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  iord, mem_write, ir_write, pc_en, pc_src, reg_dest, mem2reg,
               reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FSM sequencing the shared multicycle MIPS datapath
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master: IR fields, zero flag and memory ready in;
//          mux selects, write enables, ALU op, illegal_op pulse, debug state
//          and retired-instruction counter out.
// Parameter CNT_W sets the width of the retired counter (wraps modulo 2^CNT_W).
// Optional feature macro MULTICYCLE_CTRL_JR_EN: when defined, R-type funct 0x08
// executes as JR (state 13); when undefined it is treated as illegal.
//
// The state register is the only sequential state besides the counter; all
// datapath controls are decoded from it (plus mem_ready/zero) so that the
// datapath sees them in the same cycle the state is entered.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_if.master     bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
`ifdef MULTICYCLE_CTRL_JR_EN
        ,
        S_JR      = 4'd13
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // Supported R-type ALU functions; anything else (including JR when the
    // JR feature is off) falls through to ILLEGAL.
    function automatic logic funct_is_alu(input logic [5:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B: funct_is_alu = 1'b1;
            default:                                                funct_is_alu = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        case (f)
            6'h22, 6'h23: funct_alu_op = ALU_SUB;
            6'h24:        funct_alu_op = ALU_AND;
            6'h25:        funct_alu_op = ALU_OR;
            6'h2A, 6'h2B: funct_alu_op = ALU_SLT;
            default:      funct_alu_op = ALU_ADD;
        endcase
    endfunction

    // Next-state and retire decision.
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:      state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTE;
                    OP_BEQ:            state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU: state_d = S_ADDIEX;
                    OP_J:              state_d = S_JUMP;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            // Only lw/sw reach MEMADR, so a single compare picks the branch.
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
                retire  = bus.mem_ready;
            end
            S_EXECUTE: begin
                if (funct_is_alu(bus.funct)) begin
                    state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_JR_EN
                end else if (bus.funct == 6'h08) begin
                    state_d = S_JR;
`endif
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ILLEGAL: state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_JR_EN
            S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`endif
            // Unreachable codes recover to FETCH without retiring.
            default:   state_d = S_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Datapath control decode. Anything not assigned in a state stays 0.
    always_comb begin
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_dest   = 1'b0;
        bus.mem2reg    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 3'b000;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed,
                // together with the IR load, on the cycle memory completes.
                bus.alu_src_b = 2'b01;
                bus.alu_op    = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                bus.alu_src_b = 2'b11;
                bus.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = ALU_ADD;
            end
            S_MEMRD:  bus.iord = 1'b1;
            S_MEMWB: begin
                bus.mem2reg   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = funct_alu_op(bus.funct);
            end
            S_ALUWB: begin
                bus.reg_dest  = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = ALU_ADD;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            S_ILLEGAL: bus.illegal_op = 1'b1;
`ifdef MULTICYCLE_CTRL_JR_EN
            S_JR: begin
                bus.pc_src = 2'b11;
                bus.pc_en  = 1'b1;
            end
`endif
            default: ;
        endcase
        // While reset is held the state already reads FETCH; the strobes are
        // masked so nothing is loaded before the core is released.
        if (!rst_n) begin
            bus.ir_write = 1'b0;
            bus.pc_en    = 1'b0;
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int       st;
        logic     rdy;
        logic     irw;
        logic     pce;
        logic     rgw;
        logic     mmw;
        logic     ill;
        logic     m2r;
        bit       alu_v;
        logic [2:0] alu;
        bit       pcs_v;
        logic [1:0] pcs;
    } cyc_t;

    cyc_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_ret = 0;
    int   instr_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int st, input logic rdy, input logic irw, input logic pce,
                        input logic rgw, input logic mmw, input logic ill, input logic m2r,
                        input bit alu_v, input logic [2:0] alu,
                        input bit pcs_v, input logic [1:0] pcs);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.irw = irw; c.pce = pce; c.rgw = rgw; c.mmw = mmw;
        c.ill = ill; c.m2r = m2r; c.alu_v = alu_v; c.alu = alu; c.pcs_v = pcs_v; c.pcs = pcs;
        exp_q.push_back(c);
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction-level expectations: which cycles write what, and how long
    // each class of instruction takes given fetch and memory wait cycles.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw, output bit retires);
        logic [2:0] aop;
        bit alu_ok;
        retires = 1'b0;
        for (int i = 0; i < fw; i++) push(0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0);
        push(0, 1'b1, 1, 1, 0, 0, 0, 0, 1, 3'b010, 1, 2'b00);
        push(1, rnd_bit(), 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 2'd0);
        case (op)
            6'h23: begin
                push(2, rnd_bit(), 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 2'd0);
                for (int i = 0; i < mw; i++) push(3, 1'b0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0);
                push(3, 1'b1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 2'd0);
                push(4, rnd_bit(), 0, 0, 1, 0, 0, 1, 0, 3'd0, 0, 2'd0);
                retires = 1'b1;
            end
            6'h2B: begin
                push(2, rnd_bit(), 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 2'd0);
                for (int i = 0; i < mw; i++) push(5, 1'b0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0);
                push(5, 1'b1, 0, 0, 0, 1, 0, 0, 0, 3'd0, 0, 2'd0);
                retires = 1'b1;
            end
            6'h00: begin
                alu_ok = 1'b1;
                case (fn)
                    6'h20, 6'h21: aop = 3'b010;
                    6'h22, 6'h23: aop = 3'b110;
                    6'h24:        aop = 3'b000;
                    6'h25:        aop = 3'b001;
                    6'h2A, 6'h2B: aop = 3'b111;
                    default: begin aop = 3'b010; alu_ok = 1'b0; end
                endcase
                push(6, rnd_bit(), 0, 0, 0, 0, 0, 0, 1, aop, 0, 2'd0);
                if (alu_ok) begin
                    push(7, rnd_bit(), 0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0);
                    retires = 1'b1;
                end else begin
`ifdef MULTICYCLE_CTRL_JR_EN
                    if (fn == 6'h08) begin
                        push(13, rnd_bit(), 0, 1, 0, 0, 0, 0, 0, 3'd0, 1, 2'b11);
                        retires = 1'b1;
                    end else
`endif
                    push(12, rnd_bit(), 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 2'd0);
                end
            end
            6'h04: begin
                push(8, rnd_bit(), 0, z, 0, 0, 0, 0, 1, 3'b110, 1, 2'b01);
                retires = 1'b1;
            end
            6'h08, 6'h09: begin
                push(9, rnd_bit(), 0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 2'd0);
                push(10, rnd_bit(), 0, 0, 1, 0, 0, 0, 0, 3'd0, 0, 2'd0);
                retires = 1'b1;
            end
            6'h02: begin
                push(11, rnd_bit(), 0, 1, 0, 0, 0, 0, 0, 3'd0, 1, 2'b10);
                retires = 1'b1;
            end
            default: push(12, rnd_bit(), 0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 2'd0);
        endcase
    endtask

    // Entered and left at posedge+1; each entry covers one clock cycle.
    task automatic run_n(input int n);
        cyc_t c;
        for (int k = 0; k < n; k++) begin
            c = exp_q.pop_front();
            bus.mem_ready = c.rdy;
            #1;
            chk($sformatf("i%0d.c%0d.state", instr_no, k), 32'(bus.state), 32'(c.st));
            chk($sformatf("i%0d.c%0d.ir_write", instr_no, k), 32'(bus.ir_write), 32'(c.irw));
            chk($sformatf("i%0d.c%0d.pc_en", instr_no, k), 32'(bus.pc_en), 32'(c.pce));
            chk($sformatf("i%0d.c%0d.reg_write", instr_no, k), 32'(bus.reg_write), 32'(c.rgw));
            chk($sformatf("i%0d.c%0d.mem_write", instr_no, k), 32'(bus.mem_write), 32'(c.mmw));
            chk($sformatf("i%0d.c%0d.illegal_op", instr_no, k), 32'(bus.illegal_op), 32'(c.ill));
            chk($sformatf("i%0d.c%0d.mem2reg", instr_no, k), 32'(bus.mem2reg), 32'(c.m2r));
            if (c.alu_v) chk($sformatf("i%0d.c%0d.alu_op", instr_no, k), 32'(bus.alu_op), 32'(c.alu));
            if (c.pcs_v) chk($sformatf("i%0d.c%0d.pc_src", instr_no, k), 32'(bus.pc_src), 32'(c.pcs));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
        bit r;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        build(op, fn, z, fw, mw, r);
        run_n(exp_q.size());
        if (r) model_ret = (model_ret + 1) % (1 << CW);
        chk($sformatf("i%0d.retired", instr_no), 32'(bus.retired), 32'(model_ret));
        instr_no++;
    endtask

    logic [5:0] op_tbl [8];
    logic [5:0] fn_tbl [10];

    initial begin
        op_tbl[0] = 6'h23; op_tbl[1] = 6'h2B; op_tbl[2] = 6'h00; op_tbl[3] = 6'h04;
        op_tbl[4] = 6'h08; op_tbl[5] = 6'h09; op_tbl[6] = 6'h02; op_tbl[7] = 6'h3F;
        fn_tbl[0] = 6'h20; fn_tbl[1] = 6'h21; fn_tbl[2] = 6'h22; fn_tbl[3] = 6'h23;
        fn_tbl[4] = 6'h24; fn_tbl[5] = 6'h25; fn_tbl[6] = 6'h2A; fn_tbl[7] = 6'h2B;
        fn_tbl[8] = 6'h08; fn_tbl[9] = 6'h00;

        bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Held in reset: FETCH values with strobes masked.
        #12;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.retired", 32'(bus.retired), 32'd0);
        chk("rst.ir_write", 32'(bus.ir_write), 32'd0);
        chk("rst.pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst.alu_src_b", 32'(bus.alu_src_b), 32'b01);
        chk("rst.iord", 32'(bus.iord), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed sequence.
        do_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw with 3 memory stalls
        do_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
        do_instr(6'h00, 6'h2A, 1'b0, 0, 0);   // slt
        do_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        do_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // unsupported opcode
        do_instr(6'h00, 6'h00, 1'b0, 0, 0);   // unsupported funct
        do_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr
        do_instr(6'h02, 6'h00, 1'b0, 1, 0);   // j after a fetch stall
        do_instr(6'h08, 6'h00, 1'b0, 0, 0);   // addi
        do_instr(6'h2B, 6'h00, 1'b0, 2, 2);   // sw with stalls

        // Randomized mix; the narrow counter wraps several times.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = op_tbl[$urandom_range(0, 7)];
            if (op == 6'h3F) begin
                op = 6'($urandom_range(0, 63));
                if (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h23, 6'h2B}) op = 6'h3F;
            end
            do_instr(op, fn_tbl[$urandom_range(0, 9)], rnd_bit(),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset in the middle of a stalled lw read.
        begin
            bit r;
            bus.opcode = 6'h23;
            bus.funct  = 6'h00;
            build(6'h23, 6'h00, 1'b0, 0, 3, r);
            run_n(4);
            exp_q.delete();
            rst_n = 1'b0;
            bus.mem_ready = 1'b1;
            #1;
            chk("midrst.state", 32'(bus.state), 32'd0);
            chk("midrst.retired", 32'(bus.retired), 32'd0);
            chk("midrst.ir_write", 32'(bus.ir_write), 32'd0);
            chk("midrst.pc_en", 32'(bus.pc_en), 32'd0);
            chk("midrst.reg_write", 32'(bus.reg_write), 32'd0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            model_ret = 0;
        end
        do_instr(6'h02, 6'h00, 1'b0, 0, 0);   // first FETCH after reset loads IR
        do_instr(6'h00, 6'h25, 1'b0, 0, 0);   // or

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
